// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: constants and types shared by the instruction-fetch blocks.
//   state_t       - PC generator states (BOOT, RUN, HOLD)
//   RST_ENABLE    - active level of the synchronous reset
//   CHIPS_ENABLE  - level of ce that marks a valid fetch request
//   CHIPS_DISABLE - level of ce when no fetch is presented
//   INST_ADDR_W   - default instruction address bus width
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic RST_ENABLE    = 1'b1;
   localparam logic CHIPS_ENABLE  = 1'b1;
   localparam logic CHIPS_DISABLE = 1'b0;
   localparam int   INST_ADDR_W   = 32;

endpackage

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch stage.
//
// Parameters
//   ADDR_W     - PC width in bits
//   RESET_VEC  - first fetch address after reset
//   STEP       - sequential increment in bytes (power of two, >= 1)
// Ports
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   stall           in   hold PC and drop ce at the next transfer boundary
//   redirect        in   one-cycle pulse: branch/jump taken
//   redirect_target in   redirect destination, sampled when redirect=1
//   ready           in   instruction memory accepts the fetch this cycle
//   pc              out  fetch address (registered)
//   ce              out  fetch valid (registered)
//   misalign        out  one-cycle pulse: last redirect target was misaligned
//
// Handshake: ce is the valid of a valid/ready pair. A fetch transfers ("fires")
// in a cycle where ce=1 and ready=1. While ce=1 and ready=0 the address pc is
// frozen; a redirect seen in that window is parked in a one-entry pending
// buffer and applied as the next pc once the current fetch fires.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int                ADDR_W    = INST_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int                STEP      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic              ready,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              misalign
);

   localparam int                ALIGN_W  = $clog2(STEP);
   localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
   // Bits below the fetch granule; all zero when STEP=1.
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_W) - 64'd1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ce_q, ce_d;
   logic              mis_q, mis_d;
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_target_q, pend_target_d;

   logic [ADDR_W-1:0] aligned_target;
   logic              target_misaligned;
   logic              fire;

   assign aligned_target    = redirect_target & ~LOW_MASK;
   assign target_misaligned = |(redirect_target & LOW_MASK);
   assign fire              = ce_q & ready;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ce_d          = ce_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      mis_d         = redirect & target_misaligned;

      case (state_q)
         BOOT: begin
            // pc already holds RESET_VEC; just start presenting it.
            state_d = RUN;
            ce_d    = CHIPS_ENABLE;
         end
         RUN: begin
            if (fire) begin
               // Fresh redirect beats the parked one, which beats increment.
               if (redirect)          pc_d = aligned_target;
               else if (pend_valid_q) pc_d = pend_target_q;
               else                   pc_d = pc_q + STEP_V;
               pend_valid_d = 1'b0;
               if (stall) begin
                  state_d = HOLD;
                  ce_d    = CHIPS_DISABLE;
               end
            end else if (redirect) begin
               // Address must not move while unaccepted: park the target.
               pend_valid_d  = 1'b1;
               pend_target_d = aligned_target;
            end
         end
         HOLD: begin
            // Nothing is presented, so a redirect can land on pc directly.
            if (redirect) pc_d = aligned_target;
            if (!stall) begin
               state_d = RUN;
               ce_d    = CHIPS_ENABLE;
            end
         end
         default: begin
            state_d = BOOT;
            ce_d    = CHIPS_DISABLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VEC;
         ce_q          <= CHIPS_DISABLE;
         mis_q         <= 1'b0;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ce_q          <= ce_d;
         mis_q         <= mis_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc       = pc_q;
   assign ce       = ce_q;
   assign misalign = mis_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: two pc_gen instances sharing one set of inputs
//   dut32: ADDR_W=32, RESET_VEC=0x1000, STEP=4
//   dut16: ADDR_W=16, RESET_VEC=0xFFFE, STEP=2 (wraps to 0 on its second fetch)
// Each cycle the driver advances a reference model per instance and queues the
// outputs expected after the coming clock edge; the monitor pops and compares
// just after every rising edge.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] target = '0;
   logic        ready = 1'b0;

   logic [31:0] pc32;
   logic        ce32, mis32;
   logic [15:0] pc16;
   logic        ce16, mis16;

   int checks = 0;
   int errors = 0;
   int cycle_no = 0;

   // {misalign, ce, pc (zero-extended to 32 bits)}
   logic [33:0] exp_q0[$];
   logic [33:0] exp_q1[$];

   // Reference model state, index 0 = dut32, 1 = dut16.
   bit              m_boot[2];
   bit              m_ce[2];
   bit              m_mis[2];
   longint unsigned m_pc[2];
   bit              m_has[2];
   longint unsigned m_pend[2];

   pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0000_1000), .STEP(4)) dut32 (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_target(target), .ready(ready),
      .pc(pc32), .ce(ce32), .misalign(mis32)
   );

   pc_gen #(.ADDR_W(16), .RESET_VEC(16'hFFFE), .STEP(2)) dut16 (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_target(target[15:0]), .ready(ready),
      .pc(pc16), .ce(ce16), .misalign(mis16)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint unsigned step_of(int i);
      return (i == 0) ? 64'd4 : 64'd2;
   endfunction

   function automatic longint unsigned mod_of(int i);
      return (i == 0) ? 64'h1_0000_0000 : 64'h1_0000;
   endfunction

   function automatic longint unsigned rv_of(int i);
      return (i == 0) ? 64'h1000 : 64'hFFFE;
   endfunction

   task automatic model_step(input int i, input bit r, input bit s, input bit rd,
                             input longint unsigned t_raw, input bit rdy);
      longint unsigned st;
      longint unsigned t;
      longint unsigned at;
      logic [33:0]     e;
      st = step_of(i);
      t  = t_raw % mod_of(i);
      at = (t / st) * st;
      if (r) begin
         m_boot[i] = 1'b1;
         m_ce[i]   = 1'b0;
         m_mis[i]  = 1'b0;
         m_pc[i]   = rv_of(i);
         m_has[i]  = 1'b0;
      end else begin
         m_mis[i] = rd && ((t % st) != 0);
         if (m_boot[i]) begin
            m_boot[i] = 1'b0;
            m_ce[i]   = 1'b1;
         end else if (m_ce[i]) begin
            if (rdy) begin
               if (rd)            m_pc[i] = at;
               else if (m_has[i]) m_pc[i] = m_pend[i];
               else               m_pc[i] = (m_pc[i] + st) % mod_of(i);
               m_has[i] = 1'b0;
               if (s) m_ce[i] = 1'b0;
            end else if (rd) begin
               m_has[i]  = 1'b1;
               m_pend[i] = at;
            end
         end else begin
            if (rd) m_pc[i] = at;
            if (!s) m_ce[i] = 1'b1;
         end
      end
      e = {m_mis[i], m_ce[i], 32'(m_pc[i])};
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input bit r, input bit s, input bit rd,
                      input logic [31:0] t, input bit rdy);
      @(negedge clk);
      rst      = r;
      stall    = s;
      redirect = rd;
      target   = t;
      ready    = rdy;
      model_step(0, r, s, rd, 64'(t), rdy);
      model_step(1, r, s, rd, 64'(t), rdy);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [33:0] e;
      forever begin
         @(posedge clk);
         #1;
         cycle_no++;
         if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            checks++;
            if ({mis32, ce32, pc32} !== e) begin
               errors++;
               $display("FAIL dut32 cycle %0d: got mis=%0b ce=%0b pc=%h, expected mis=%0b ce=%0b pc=%h",
                        cycle_no, mis32, ce32, pc32, e[33], e[32], e[31:0]);
            end
         end
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checks++;
            if ({mis16, ce16, 16'h0000, pc16} !== e) begin
               errors++;
               $display("FAIL dut16 cycle %0d: got mis=%0b ce=%0b pc=%h, expected mis=%0b ce=%0b pc=%h",
                        cycle_no, mis16, ce16, pc16, e[33], e[32], e[15:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset and boot: ce low during reset, first fetch one cycle after.
      cyc(1, 0, 0, 32'h0, 1);
      cyc(1, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);   // BOOT -> ce=1 at RESET_VEC
      cyc(0, 0, 0, 32'h0, 1);   // 1004 / 0000 (wrap on dut16)
      cyc(0, 0, 0, 32'h0, 1);   // 1008 / 0002

      // Backpressure at 0x10 with a redirect parked in wait cycle 2.
      cyc(0, 0, 1, 32'h10, 1);  // pc -> 0x10
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 1, 32'h80, 0);
      cyc(0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 1);   // fire at 0x10 -> 0x80
      cyc(0, 0, 0, 32'h0, 1);   // 0x84

      // Stall: ignored until fire, then HOLD; redirect in HOLD; release.
      cyc(0, 1, 0, 32'h0, 0);
      cyc(0, 1, 0, 32'h0, 1);   // fire -> ce=0, pc=next
      cyc(0, 1, 1, 32'h200, 1); // HOLD redirect -> pc=0x200
      cyc(0, 1, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);   // release -> ce=1 at 0x200
      cyc(0, 0, 0, 32'h0, 1);

      // Misaligned redirect in a fire cycle.
      cyc(0, 0, 1, 32'h103, 1); // pc=0x100 (0x102 on dut16), misalign=1
      cyc(0, 0, 0, 32'h0, 1);   // misalign back to 0

      // Fresh redirect beats the pending target.
      cyc(0, 0, 1, 32'h40, 0);  // park 0x40
      cyc(0, 0, 1, 32'h300, 1); // fire: 0x300 wins
      cyc(0, 0, 0, 32'h0, 1);   // 0x304, pending cleared

      // Redirect together with stall in a fire cycle.
      cyc(0, 1, 1, 32'h600, 1);
      cyc(0, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);

      // Reset mid-wait drops the request and pending target.
      cyc(0, 0, 1, 32'h500, 0);
      cyc(1, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);
      cyc(0, 0, 0, 32'h0, 1);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 63) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 5) == 0),
             $urandom,
             ($urandom_range(0, 2) != 0));
      end
      cyc(0, 0, 0, 32'h0, 1);

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 20 && (exp_q0.size() > 0 || exp_q1.size() > 0); k++)
         @(posedge clk);
      #2;
      if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d entries left, expected 0/0",
                  exp_q0.size(), exp_q1.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the instruction-fetch stage. It replaces the fixed 32-bit free-running PC with:
- a configurable reset vector, address width and fetch step;
- a valid/ready fetch handshake toward instruction memory;
- a pipeline stall input;
- branch/jump redirect with a one-entry pending buffer, so redirects arriving during an unaccepted fetch are not lost.

It sits between the control unit (stall, redirect) and the instruction-memory port (pc, ce).

## Interface
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 0, first fetch address after reset. Width ADDR_W.
- STEP, 4, sequential increment in bytes. Power of two, ≥1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high (`RstEnable`).
- stall  in  1  hold PC and deassert ce at the next transfer boundary.
- redirect  in  1  one-cycle pulse: branch/jump taken.
- redirect_target  in  ADDR_W  redirect destination, sampled when redirect=1.
- ready  in  1  memory accepts the fetch at pc this cycle.
- pc  out  ADDR_W  fetch address, registered.
- ce  out  1  fetch valid (`ChipsEnable`), registered.
- misalign  out  1  one-cycle pulse: the last redirect target had nonzero low log2(STEP) bits.

## Operation
- Transfer ("fire") occurs when ce=1 and ready=1.
- Reset (rst=1 at edge), regardless of state:
  - state=BOOT, pc=RESET_VEC, ce=0;
  - pending buffer cleared, misalign=0.
- BOOT:
  - next state RUN, ce=1, pc stays RESET_VEC;
  - first fetch is presented the cycle after rst deasserts.
- RUN (ce=1) with fire:
  - next pc selection, priority order: redirect this cycle → aligned redirect_target; else pending valid → pending target; else pc+STEP;
  - pending buffer cleared;
  - if stall=1: state→HOLD, ce=0; else stay RUN.
- RUN without fire:
  - pc and ce held stable; the valid/ready rule forbids changing the address while unaccepted;
  - stall is ignored until fire;
  - redirect=1 loads pending buffer (valid=1, target = aligned redirect_target). A newer redirect overwrites an older pending one.
- HOLD (ce=0):
  - redirect=1 → pc=aligned target immediately;
  - stall=0 → state RUN, ce=1 next cycle;
  - pending buffer is always empty in HOLD.
- Alignment and misalign:
  - target low log2(STEP) bits are forced to 0;
  - misalign=1 for exactly one cycle after any redirect whose raw target had those bits nonzero;
  - the aligned target is still used.
- Arithmetic: pc+STEP is modulo 2^ADDR_W; wrap from all-ones region to 0 is silent.
- Simultaneous events:
  - rst overrides everything;
  - redirect beats pending beats increment;
  - redirect and stall in the same fire cycle → pc=target, state HOLD.

## Timing
- All outputs registered; no combinational input→output path.
- Reset values: pc=RESET_VEC, ce=0, misalign=0.
- Latency:
  - rst deassert → ce=1: 1 cycle (BOOT);
  - redirect in RUN with fire → new pc next cycle;
  - redirect without fire → applied the cycle after the eventual fire;
  - stall release in HOLD → ce=1 next cycle.
- Steady state: one address per cycle while ready=1 and stall=0.
- Reset mid-wait (ce=1, ready=0): request dropped, pending lost, BOOT sequence restarts.

## Structure
- `defines.vh`: `RstEnable`, `ChipsEnable`/`ChipsDisable`, `InstAddrBus` default width, and the three state encodings (BOOT, RUN, HOLD) as shared constants for reuse by the fetch/ctrl blocks.
- Single module; no sub-module. The pending buffer (valid bit + ADDR_W register) stays inline.
- Alignment mask is derived locally from STEP via $clog2.

## Test plan
- Reset/boot, RESET_VEC=32'h0000_1000, ready=1: after rst low, cycle 1 ce=1 pc=1000; then 1004, 1008; ce=0 on every rst cycle.
- Backpressure, ready=0 for 3 cycles at pc=0x10: pc stays 0x10 with ce=1. redirect to 0x80 in wait cycle 2, then ready=1 → fire at 0x10, next pc=0x80, then 0x84.
- Stall:
  - stall=1 while ready=0 → ce held until fire, then ce=0 and pc=next;
  - redirect 0x200 during HOLD → pc=0x200;
  - stall=0 → ce=1 next cycle at 0x200.
- Misalign and priority:
  - redirect 0x103 (STEP=4) in fire cycle → pc=0x100, misalign=1 for one cycle;
  - redirect during fire with a pending target 0x40 → new target wins, pending cleared.
- Wrap and params:
  - ADDR_W=16, STEP=2, start 0xFFFE, ready=1 → next pc 0x0000, no misalign;
  - rst asserted mid-wait → pc=RESET_VEC, pending discarded.
